serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial ripple adder: the additive counterpart of the half_subtractor family in Comb/Arithmetic. It accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake. It adds them LSB-first through one full-adder cell and a carry flip-flop, taking one bit per clock. It presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. Used where area matters more than throughput, and as the sequential reference for the combinational adder/subtractor blocks.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and carry_in valid
in_ready  output  1  block can accept operands (high only in IDLE and rst low)
augend  input  WIDTH  first operand, sampled on input handshake
addend  input  WIDTH  second operand, sampled on input handshake
carry_in  input  1  carry into bit 0, sampled on input handshake
out_valid  output  1  sum and carry_out valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  (augend + addend + carry_in) mod 2^WIDTH
carry_out  output  1  bit WIDTH of the full addition
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst sampled high at an edge -> state IDLE; out_valid=0, sum=0, carry_out=0, busy=0. in_ready is 0 while rst is high.
- Reset has priority over every other event, including a handshake in the same cycle. Reset mid-RUN or mid-DONE aborts the operation; no out_valid is ever produced for it.
- FSM states:
  - IDLE: in_ready=1.
    - in_valid & in_ready at an edge: load augend/addend into shift registers, carry_in into the carry flop, clear the bit counter, clear the sum shift register, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - s = a[0]^b[0]^c; c <= majority(a[0],b[0],c).
    - Operand registers shift right by 1.
    - Sum register shifts right, inserting s at MSB.
    - Counter increments.
    - The WIDTH-th RUN edge moves to DONE, with the final carry stored into carry_out.
  - DONE: out_valid=1. sum and carry_out are held stable until out_ready=1 at an edge, then go to IDLE and drop out_valid.
- Latency: input handshake at edge k -> out_valid high from edge k+WIDTH. It stays high until the consumer handshake.
- Throughput: at most one result per WIDTH+2 cycles with out_ready tied high.
- No overlap: in_ready=0 in RUN/DONE; in_valid is ignored there, and operand changes have no effect.
- sum and carry_out are registered outputs. During RUN their values are don't-care for the bench; they are valid only while out_valid=1.
- WIDTH=1: a single RUN cycle; behaves as a registered full adder.
- Counter width: clog2(WIDTH+1) bits; no wrap occurs inside a legal operation.
- Overflow is not an error: the carry out of bit WIDTH-1 goes only to carry_out.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, 8'h00 + 8'h00, cin=0, out_ready=1 -> sum=8'h00, carry_out=0; out_valid first high exactly 8 edges after the accept edge.
- WIDTH=8, 8'hFF + 8'h01, cin=0 -> sum=8'h00, carry_out=1. Then 8'hA5 + 8'h5A, cin=1 -> sum=8'h00, carry_out=1. Then 8'h3C + 8'h42, cin=0 -> sum=8'h7E, carry_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, driving in_valid=1 with new operands. Required: sum/carry_out stable, in_ready=0, the new operands ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst for one cycle 3 edges into RUN. Required: in_ready=0 during rst, state IDLE after, out_valid never asserts for the aborted operands. The next operation 8'h10 + 8'h20 gives sum=8'h30.
- Exhaustive, WIDTH=2: all 32 combinations of augend, addend and cin, plus random out_ready stalls. Check {carry_out,sum} against augend+addend+cin; count exactly 32 out_valid handshakes.
- WIDTH=1: the eight full-adder truth-table rows -> sum = a^b^cin, carry_out = majority; 1-edge latency from accept to out_valid.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand channel in, result channel out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] augend;
  logic [WIDTH-1:0] addend;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, augend, addend, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );

  // Adder side
  modport slave (
    input  in_valid, augend, addend, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first,
// one bit per clock, with valid/ready handshakes on operands and result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int unsigned     CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_idle;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_shift;

  // Full-adder cell on the current LSBs and the next sum-register value
  // (shift right, new bit at MSB; written this way so WIDTH=1 needs no slice).
  always_comb begin
    w_s                    = r_a[0] ^ r_b[0] ^ r_c;
    w_c                    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_s;
  end

  // Control FSM and datapath; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.augend;
            r_b     <= bus.addend;
            r_c     <= bus.carry_in;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_idle  <= 1'b0;
          end
        end
        RUN: begin
          r_c   <= w_c;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_sum <= w_sum_shift;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cout      <= w_c;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_idle      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_idle      <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is masked by rst directly so it drops in the reset cycle itself.
  assign bus.in_ready  = r_idle & ~rst;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;
  assign bus.busy      = r_busy;
endmodule
